st_pushpop_seq: RTL

Parametrised second-generation stack unit. It sequences multi-register PUSH/POP, one memory beat per cycle. It owns the stack pointer, supports SP±immediate adjust, and detects stack overflow/underflow against configurable limits. It sits beside the processor datapath: it drives data-memory address/strobes and register-file indices, and the datapath moves the data.

---
 rtl/st_pushpop_seq.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/st_pushpop_seq.sv
// st_pushpop_seq - stack sequencer for multi-register PUSH/POP and SP adjust.
//
// Issues one data-memory beat per cycle for PUSH/POP. The datapath moves the
// data; this block provides addresses, strobes and register-file indices.
// It owns the stack pointer and rejects any operation that would leave SP
// outside [STACK_LIMIT, STACK_BASE].
//
// Ports:
//   clk, resetn         clock (rising edge), asynchronous active-low reset
//   start, op           request (accepted in IDLE only); 00 PUSH 01 POP 10 ADD 11 SUB
//   reg_list            R0..R(NREG-1) in bits [NREG-1:0], LR/PC in bit NREG
//   imm                 SP adjust amount in words (zero-extended)
//   fault_clr           clears the sticky fault flag
//   busy, done, err     status; err qualifies done
//   fault               sticky error flag
//   dmem_addr/wr/rd     data-memory address and strobes (load data returns next cycle)
//   rf_rd_addr, lr_sel  store-data source (register index or LR)
//   rf_wr_addr, rf_wr   load-data destination register and write strobe
//   pc_wr               PC load strobe (POP with PC bit)
//   sp                  current stack pointer
module st_pushpop_seq #(
    parameter int                ADDR_W      = 16,
    parameter int                NREG        = 8,
    parameter int                IMM_W       = 8,
    parameter int                STEP        = 1,
    parameter logic [ADDR_W-1:0] SP_RESET    = 16'h0100,
    parameter logic [ADDR_W-1:0] STACK_BASE  = 16'h0100,
    parameter logic [ADDR_W-1:0] STACK_LIMIT = 16'h00F0,
    localparam int               RA_W        = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [NREG:0]     reg_list,
    input  logic [IMM_W-1:0]  imm,
    input  logic              fault_clr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              fault,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_wr,
    output logic              dmem_rd,
    output logic [RA_W-1:0]   rf_rd_addr,
    output logic              lr_sel,
    output logic [RA_W-1:0]   rf_wr_addr,
    output logic              rf_wr,
    output logic              pc_wr,
    output logic [ADDR_W-1:0] sp
);

    localparam int                IDX_W   = $clog2(NREG + 1);
    localparam int                CNT_W   = $clog2(NREG + 2);
    localparam int                OFF_W   = ADDR_W + 1;
    localparam logic [OFF_W-1:0]  STEP_X  = OFF_W'(STEP);
    localparam logic [ADDR_W-1:0] STEP_A  = ADDR_W'(STEP);
    localparam logic [OFF_W-1:0]  BASE_X  = {1'b0, STACK_BASE};
    localparam logic [OFF_W-1:0]  LIMIT_X = {1'b0, STACK_LIMIT};
    localparam logic [NREG:0]     LSB_ONE = (NREG + 1)'(1);
    localparam logic [IDX_W-1:0]  TOP_IDX = IDX_W'(NREG);

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_SUB  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] popcnt(input logic [NREG:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i <= NREG; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // Index of the lowest set bit; gives ascending register order with LR/PC last.
    function automatic logic [IDX_W-1:0] lowest(input logic [NREG:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NREG; i >= 0; i--) begin
            if (v[i]) begin
                r = IDX_W'(i);
            end
        end
        return r;
    endfunction

    state_t            state_q;
    logic              pop_q;
    logic [NREG:0]     mask_q;      // registers still to be transferred
    logic [ADDR_W-1:0] sp_q, sp_new_q;
    logic [RA_W-1:0]   cur_ra_q;    // register of the beat now on the bus
    logic              cur_top_q;   // beat now on the bus is the LR/PC slot
    logic              busy_q, done_q, err_q, fault_q;
    logic [ADDR_W-1:0] dmem_addr_q;
    logic              dmem_wr_q, dmem_rd_q, lr_sel_q, rf_wr_q, pc_wr_q;
    logic [RA_W-1:0]   rf_rd_addr_q, rf_wr_addr_q;

    logic [CNT_W-1:0]  cnt_s;
    logic [OFF_W-1:0]  sp_x_s, off_s, sum_s, diff_s;
    logic              err_s;
    logic [NREG:0]     src_s, rest_s;
    logic [IDX_W-1:0]  idx_s;
    logic              top_s;

    // Limit checks in ADDR_W+1 bits so a wrap in either direction is caught,
    // plus selection of the next register to transfer.
    always_comb begin
        sp_x_s = {1'b0, sp_q};
        cnt_s  = popcnt(reg_list);
        off_s  = op[1] ? (OFF_W'(imm) * STEP_X) : (OFF_W'(cnt_s) * STEP_X);
        sum_s  = sp_x_s + off_s;
        diff_s = sp_x_s - off_s;
        case (op)
            OP_PUSH: err_s = (sp_x_s < off_s) || (diff_s < LIMIT_X);
            OP_POP:  err_s = (sum_s > BASE_X);
            OP_ADD:  err_s = (sum_s > BASE_X) || (sum_s < LIMIT_X);
            OP_SUB:  err_s = (sp_x_s < off_s) || (diff_s < LIMIT_X) || (diff_s > BASE_X);
            default: err_s = 1'b1;
        endcase
        if (state_q == S_IDLE) begin
            src_s = reg_list;
        end else begin
            src_s = mask_q;
        end
        idx_s  = lowest(src_s);
        top_s  = (idx_s == TOP_IDX);
        rest_s = src_s & ~(LSB_ONE << idx_s);
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            pop_q        <= 1'b0;
            mask_q       <= '0;
            sp_q         <= SP_RESET;
            sp_new_q     <= SP_RESET;
            cur_ra_q     <= '0;
            cur_top_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            fault_q      <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wr_q    <= 1'b0;
            dmem_rd_q    <= 1'b0;
            lr_sel_q     <= 1'b0;
            rf_rd_addr_q <= '0;
            rf_wr_q      <= 1'b0;
            pc_wr_q      <= 1'b0;
            rf_wr_addr_q <= '0;
        end else begin
            // Sticky fault: a new error wins over a simultaneous clear.
            if ((state_q == S_IDLE) && start && err_s) begin
                fault_q <= 1'b1;
            end else if (fault_clr) begin
                fault_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        pop_q  <= op[0];
                        if (err_s) begin
                            state_q  <= S_FIN;
                            done_q   <= 1'b1;
                            err_q    <= 1'b1;
                            sp_new_q <= sp_q;
                        end else if (op[1]) begin
                            state_q  <= S_FIN;
                            done_q   <= 1'b1;
                            sp_new_q <= op[0] ? diff_s[ADDR_W-1:0] : sum_s[ADDR_W-1:0];
                        end else if (reg_list == '0) begin
                            state_q  <= S_FIN;
                            done_q   <= 1'b1;
                            sp_new_q <= sp_q;
                        end else begin
                            // First beat goes out in cycle 1, at the lowest address.
                            state_q      <= S_XFER;
                            mask_q       <= rest_s;
                            sp_new_q     <= op[0] ? sum_s[ADDR_W-1:0] : diff_s[ADDR_W-1:0];
                            dmem_addr_q  <= op[0] ? sp_q : diff_s[ADDR_W-1:0];
                            dmem_wr_q    <= !op[0];
                            dmem_rd_q    <= op[0];
                            lr_sel_q     <= !op[0] && top_s;
                            rf_rd_addr_q <= (!op[0] && !top_s) ? idx_s[RA_W-1:0] : '0;
                            cur_ra_q     <= idx_s[RA_W-1:0];
                            cur_top_q    <= top_s;
                        end
                    end
                end
                S_XFER: begin
                    // Load data for the beat now on the bus returns next cycle.
                    rf_wr_q      <= dmem_rd_q && !cur_top_q;
                    pc_wr_q      <= dmem_rd_q && cur_top_q;
                    rf_wr_addr_q <= (dmem_rd_q && !cur_top_q) ? cur_ra_q : '0;
                    if (mask_q != '0) begin
                        mask_q       <= rest_s;
                        dmem_addr_q  <= dmem_addr_q + STEP_A;
                        dmem_wr_q    <= !pop_q;
                        dmem_rd_q    <= pop_q;
                        lr_sel_q     <= !pop_q && top_s;
                        rf_rd_addr_q <= (!pop_q && !top_s) ? idx_s[RA_W-1:0] : '0;
                        cur_ra_q     <= idx_s[RA_W-1:0];
                        cur_top_q    <= top_s;
                    end else begin
                        state_q      <= S_FIN;
                        done_q       <= 1'b1;
                        dmem_addr_q  <= '0;
                        dmem_wr_q    <= 1'b0;
                        dmem_rd_q    <= 1'b0;
                        lr_sel_q     <= 1'b0;
                        rf_rd_addr_q <= '0;
                    end
                end
                S_FIN: begin
                    state_q      <= S_IDLE;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                    err_q        <= 1'b0;
                    rf_wr_q      <= 1'b0;
                    pc_wr_q      <= 1'b0;
                    rf_wr_addr_q <= '0;
                    sp_q         <= sp_new_q;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign fault      = fault_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wr    = dmem_wr_q;
    assign dmem_rd    = dmem_rd_q;
    assign rf_rd_addr = rf_rd_addr_q;
    assign lr_sel     = lr_sel_q;
    assign rf_wr_addr = rf_wr_addr_q;
    assign rf_wr      = rf_wr_q;
    assign pc_wr      = pc_wr_q;
    assign sp         = sp_q;

endmodule
